uart_rx_fifo_ext: RTL and testbench

//  Self-contained UART receive subsystem: programmable oversample tick generator, 2-flop input synchroniser,
//  5..8-bit frame receiver with parity and stop checking, break detection, and an error-tagged FWFT FIFO

---
 rtl/uart_rx_fifo_ext.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_ext.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ext.sv
// rtl/uart_rx_fifo_ext.sv - UART receiver with runtime framing, break detect and error-tagged FWFT FIFO
//
// Purpose: oversample tick generator, 2-flop rx synchroniser, 5..8-bit frame
// receiver (optional even/odd parity, 1 or 2 stop bits), break detection and a
// first-word-fall-through FIFO whose entries carry {break, parity, stop} flags,
// plus a sticky overrun flag and an idle-timeout flag.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_rx                  asynchronous serial line
//   i_div                 oversample tick period = i_div+1 clocks
//   i_d_len               data bits 00=5 01=6 10=7 11=8
//   i_s_num               0: one stop bit, 1: two stop bits
//   i_par                 00/11 none, 01 even, 10 odd
//   i_rd, i_flush         pop head entry, empty the FIFO
//   i_clr_ovr             clear o_overrun
//   o_rd_data, o_rd_err   head entry (zero when empty)
//   o_empty, o_full       FIFO status
//   o_count               entries held
//   o_overrun             sticky: a frame was dropped on a full FIFO
//   o_timeout             data waiting and line idle TO_BITS bit periods
//   o_busy                receiver is in a frame or waiting out a break
module uart_rx_fifo_ext #(
  parameter int SAMPLING_RATE = 16,
  parameter int DEPTH         = 16,
  parameter int DIV_W         = 16,
  parameter int TO_BITS       = 40
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx,
  input  logic [DIV_W-1:0]         i_div,
  input  logic [1:0]               i_d_len,
  input  logic                     i_s_num,
  input  logic [1:0]               i_par,
  input  logic                     i_rd,
  input  logic                     i_flush,
  input  logic                     i_clr_ovr,
  output logic [7:0]               o_rd_data,
  output logic [2:0]               o_rd_err,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overrun,
  output logic                     o_timeout,
  output logic                     o_busy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SC_W   = $clog2(SAMPLING_RATE);
  localparam int TO_LIM = TO_BITS * SAMPLING_RATE;
  localparam int TO_W   = $clog2(TO_LIM + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
  state_t state, state_nx;

  logic             rx_s1, rx_s2, rx_d;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, start_edge, sample, at_pt, in_frame;
  logic [SC_W-1:0]  s_cnt;
  logic [1:0]       cfg_len, cfg_par;
  logic             cfg_snum;
  logic [7:0]       data_sr;
  logic [2:0]       bit_cnt;
  logic             stop_cnt, stop_zero, stop_one, par_bit;
  logic             par_en, par_odd, last_data, last_stop;
  logic             brk_now, par_err_now, stop_err_now;
  logic             frame_wr;
  logic [10:0]      frame_word;
  logic [10:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_rd, do_wr;
  logic [TO_W-1:0]  to_cnt;
  logic [10:0]      head;

  // rx_d holds the previous synced value so only a genuine 1->0 edge starts a frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_edge = (state == S_IDLE) && rx_d && !rx_s2;
  assign tick       = (div_cnt >= i_div);

  // Prescaler restarts on a start edge so every frame's ticks are phase-aligned to it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  assign in_frame     = (state == S_START) || (state == S_DATA) || (state == S_PAR) || (state == S_STOP);
  assign at_pt        = (state == S_START) ? (s_cnt == SC_W'(SAMPLING_RATE/2 - 1))
                                           : (s_cnt == SC_W'(SAMPLING_RATE - 1));
  assign sample       = tick && at_pt && in_frame;
  assign par_en       = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign par_odd      = (cfg_par == 2'b10);
  assign last_data    = (bit_cnt == (3'd4 + {1'b0, cfg_len}));
  assign last_stop    = (stop_cnt == cfg_snum);
  assign stop_err_now = stop_zero || !rx_s2;
  assign par_err_now  = par_en && ((^data_sr ^ par_bit) != par_odd);
  // Break: every sampled bit of the frame (data, parity, all stops) was low
  assign brk_now      = (data_sr == 8'd0) && (!par_en || !par_bit) && !stop_one && !rx_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_edge) state_nx = S_START;
      S_START: if (sample) state_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (sample && last_data) state_nx = par_en ? S_PAR : S_STOP;
      S_PAR:   if (sample) state_nx = S_STOP;
      S_STOP:  if (sample && last_stop) state_nx = brk_now ? S_BRK : S_IDLE;
      S_BRK:   if (rx_s2) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_cnt      <= '0;
      cfg_len    <= '0;
      cfg_par    <= '0;
      cfg_snum   <= 1'b0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      stop_zero  <= 1'b0;
      stop_one   <= 1'b0;
      par_bit    <= 1'b0;
      frame_wr   <= 1'b0;
      frame_word <= '0;
    end else begin
      frame_wr <= 1'b0;
      if (start_edge) begin
        s_cnt     <= '0;
        cfg_len   <= i_d_len;
        cfg_par   <= i_par;
        cfg_snum  <= i_s_num;
        data_sr   <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        stop_zero <= 1'b0;
        stop_one  <= 1'b0;
        par_bit   <= 1'b0;
      end else if (tick && in_frame) begin
        s_cnt <= sample ? '0 : s_cnt + 1'b1;
        if (sample) begin
          case (state)
            S_DATA: begin
              data_sr[bit_cnt] <= rx_s2;
              bit_cnt          <= bit_cnt + 1'b1;
            end
            S_PAR: par_bit <= rx_s2;
            S_STOP: begin
              stop_cnt <= stop_cnt + 1'b1;
              if (rx_s2) stop_one  <= 1'b1;
              else       stop_zero <= 1'b1;
              if (last_stop) begin
                frame_wr   <= 1'b1;
                frame_word <= {brk_now, par_err_now, stop_err_now, data_sr};
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // FIFO: flush outranks both ports; a read on the same cycle frees room for a write when full
  assign o_count = wr_ptr - rd_ptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign do_rd   = i_rd && !o_empty && !i_flush;
  assign do_wr   = frame_wr && !i_flush && (!o_full || do_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= frame_word;
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign o_rd_data = o_empty ? 8'd0 : head[7:0];
  assign o_rd_err  = o_empty ? 3'd0 : head[10:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    o_overrun <= 1'b0;
    else if (frame_wr && o_full && !do_rd && !i_flush) o_overrun <= 1'b1;
    else if (i_clr_ovr)                              o_overrun <= 1'b0;
  end

  // Idle timeout counts ticks only while waiting in IDLE with data held; saturates at the limit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      to_cnt <= '0;
    else if (i_rd || frame_wr || i_flush || start_edge || o_empty)
      to_cnt <= '0;
    else if ((state == S_IDLE) && tick && (to_cnt != TO_W'(TO_LIM)))
      to_cnt <= to_cnt + 1'b1;
  end

  assign o_timeout = !o_empty && (to_cnt == TO_W'(TO_LIM));
  assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_ext.sv
// tb/tb_uart_rx_fifo_ext.sv - self-checking bench for uart_rx_fifo_ext
module tb_uart_rx_fifo_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] div;
  logic [1:0]  d_len;
  logic        s_num;
  logic [1:0]  par;
  logic        rd, flush, clr_ovr;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        empty, full, overrun, timeout, busy;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_clks = 16;

  uart_rx_fifo_ext dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_div(div), .i_d_len(d_len),
    .i_s_num(s_num), .i_par(par), .i_rd(rd), .i_flush(flush), .i_clr_ovr(clr_ovr),
    .o_rd_data(rd_data), .o_rd_err(rd_err), .o_empty(empty), .o_full(full),
    .o_count(count), .o_overrun(overrun), .o_timeout(timeout), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  // Reference: expected FIFO entry from what was put on the line
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input int nbits, input logic [1:0] pmode,
                                            input logic pbit, input int nstop, input logic [1:0] stops);
    logic [7:0] dm;
    logic pen, perr, serr, brk, all_low;
    dm      = d & ((8'd1 << nbits) - 8'd1);
    pen     = (pmode == 2'd1) || (pmode == 2'd2);
    perr    = pen && ((^dm ^ pbit) != (pmode == 2'd2));
    all_low = (nstop == 2) ? (stops == 2'b00) : (stops[0] == 1'b0);
    serr    = (nstop == 2) ? (stops != 2'b11) : (stops[0] == 1'b0);
    brk     = (dm == 8'd0) && (!pen || !pbit) && all_low;
    return {brk, perr, serr, dm};
  endfunction

  function automatic logic good_par(input logic [7:0] d, input int nbits, input logic [1:0] pmode);
    logic [7:0] dm;
    dm = d & ((8'd1 << nbits) - 8'd1);
    return (^dm) ^ (pmode == 2'd2);
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] pmode,
                            input logic pbit, input int nstop, input logic [1:0] stops);
    d_len = 2'(nbits - 5);
    s_num = (nstop == 2);
    par   = pmode;
    rx = 1'b0;
    cyc(bit_clks);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      cyc(bit_clks);
    end
    if (pmode == 2'd1 || pmode == 2'd2) begin
      rx = pbit;
      cyc(bit_clks);
    end
    for (int i = 0; i < nstop; i++) begin
      rx = stops[i];
      cyc(bit_clks);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if ({full, overrun, timeout, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {full, overrun, timeout, busy}); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if ({rd_err, rd_data} !== 11'd0) begin n_fail++; $display("FAIL reset_head: got %h want 0", {rd_err, rd_data}); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 8, 2'd0, 1'b0, 1, 2'b11);
    cyc(bit_clks);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL 8n1_count: got %0d want 1", count); end
    n_checks++; if ({rd_err, rd_data} !== {3'b000, 8'hA5}) begin n_fail++; $display("FAIL 8n1_head: got %h want %h", {rd_err, rd_data}, {3'b000, 8'hA5}); end
    pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL 8n1_empty_after_rd: got %b want 1", empty); end
  endtask

  task automatic test_7e2();
    logic bad;
    bad = ~good_par(8'h35, 7, 2'd1);
    send_frame(8'h35, 7, 2'd1, bad, 2, 2'b11);
    cyc(bit_clks);
    n_checks++; if ({rd_err, rd_data} !== {3'b010, 8'h35}) begin n_fail++; $display("FAIL 7e2_parity: got %h want %h", {rd_err, rd_data}, {3'b010, 8'h35}); end
    pop();
    send_frame(8'h35, 7, 2'd1, bad, 2, 2'b01);
    cyc(bit_clks);
    n_checks++; if ({rd_err, rd_data} !== {3'b011, 8'h35}) begin n_fail++; $display("FAIL 7e2_par_stop: got %h want %h", {rd_err, rd_data}, {3'b011, 8'h35}); end
    pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL 7e2_empty: got %b want 1", empty); end
  endtask

  task automatic test_break();
    d_len = 2'b11; s_num = 1'b0; par = 2'b00;
    rx = 1'b0;
    cyc(12 * bit_clks);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b want 1", busy); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL break_one_entry: got %0d want 1", count); end
    rx = 1'b1;
    cyc(bit_clks);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_high: got %b want 0", busy); end
    n_checks++; if ({rd_err, rd_data} !== {3'b101, 8'h00}) begin n_fail++; $display("FAIL break_head: got %h want %h", {rd_err, rd_data}, {3'b101, 8'h00}); end
    pop();
    send_frame(8'h3C, 8, 2'd0, 1'b0, 1, 2'b11);
    cyc(bit_clks);
    n_checks++; if ({count, rd_err, rd_data} !== {5'd1, 3'b000, 8'h3C}) begin n_fail++; $display("FAIL break_next_frame: got %h want %h", {count, rd_err, rd_data}, {5'd1, 3'b000, 8'h3C}); end
    pop();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    cyc(4);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    rx = 1'b1;
    cyc(12);
    n_checks++; if ({busy, count} !== 6'd0) begin n_fail++; $display("FAIL glitch_ignored: got busy=%b count=%0d want 0 0", busy, count); end
  endtask

  task automatic test_timeout();
    send_frame(8'h5A, 8, 2'd0, 1'b0, 1, 2'b11);
    cyc(560);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", timeout); end
    cyc(100);
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1", timeout); end
    pop();
    n_checks++; if ({timeout, empty} !== 2'b01) begin n_fail++; $display("FAIL timeout_clear: got %b want 01", {timeout, empty}); end
  endtask

  task automatic test_overrun();
    logic [10:0] q[$];
    logic [7:0]  d;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) q.push_back(exp_frame(d, 8, 2'd0, 1'b0, 1, 2'b11));
      send_frame(d, 8, 2'd0, 1'b0, 1, 2'b11);
    end
    cyc(bit_clks);
    n_checks++; if ({full, count, overrun} !== {1'b1, 5'd16, 1'b1}) begin n_fail++; $display("FAIL overrun_full: got full=%b count=%0d ovr=%b want 1 16 1", full, count, overrun); end
    clr_ovr = 1'b1; cyc(1); clr_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if ({rd_err, rd_data} !== q[i]) begin n_fail++; $display("FAIL overrun_order[%0d]: got %h want %h", i, {rd_err, rd_data}, q[i]); end
      pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL overrun_drained: got %b want 1", empty); end
  endtask

  task automatic test_flush();
    send_frame(8'h11, 8, 2'd0, 1'b0, 1, 2'b11);
    send_frame(8'h22, 8, 2'd0, 1'b0, 1, 2'b11);
    cyc(bit_clks);
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    flush = 1'b1; cyc(1); flush = 1'b0;
    n_checks++; if ({empty, count} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL flush_empty: got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [1:0]  pm, st;
    logic        pb;
    int          nb, ns;
    logic [10:0] e;
    for (int i = 0; i < 14; i++) begin
      div      = 16'($urandom_range(0, 2));
      bit_clks = 16 * (int'(div) + 1);
      d  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      nb = $urandom_range(5, 8);
      pm = 2'($urandom);
      ns = $urandom_range(1, 2);
      st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      pb = good_par(d, nb, pm) ^ ($urandom_range(0, 3) == 0);
      e  = exp_frame(d, nb, pm, pb, ns, st);
      send_frame(d, nb, pm, pb, ns, st);
      cyc(2 * bit_clks);
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want 1", i, count); end
      n_checks++; if ({rd_err, rd_data} !== e) begin n_fail++; $display("FAIL rand_entry[%0d]: got %h want %h", i, {rd_err, rd_data}, e); end
      pop();
    end
    div = '0;
    bit_clks = 16;
    cyc(4);
  endtask

  task automatic test_reset_midframe();
    d_len = 2'b11; s_num = 1'b0; par = 2'b00;
    rx = 1'b0;
    cyc(40);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #2;
    n_checks++; if ({busy, empty} !== 2'b01) begin n_fail++; $display("FAIL midframe_reset: got %b want 01", {busy, empty}); end
    cyc(1);
    rst_n = 1'b1;
    rx = 1'b1;
    cyc(12 * bit_clks);
    n_checks++; if ({busy, count} !== 6'd0) begin n_fail++; $display("FAIL midframe_discard: got busy=%b count=%0d want 0 0", busy, count); end
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; div = '0; d_len = 2'b11; s_num = 1'b0; par = 2'b00;
    rd = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_break();
    test_glitch();
    test_timeout();
    test_overrun();
    test_flush();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
